lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles an access may spend in ISSUE+WAIT before it is aborted with an error.
REQ-002 SHALL have port clk  in  1  clock; the design uses one clock.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  access request from execute stage.
REQ-005 SHALL have port req_ready  out  1  request accepted.
REQ-006 SHALL have port req_wen  in  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  in  3  access size/sign code.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, LSB-aligned.
REQ-010 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out 32, resp_err out 1; together these are the result handshake back to the core.
REQ-011 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_wen out 1, mem_addr out 32, mem_wdata out 32, mem_wmask out 4; together these are the bus request channel.
REQ-012 SHALL have ports mem_rsp_valid in 1, mem_rsp_ready out 1, mem_rsp_rdata in 32, mem_rsp_err in 1; together these are the bus response channel.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE; mem_req_valid=1 only in ISSUE; mem_rsp_ready=1 only in WAIT; resp_valid=1 only in RESP.
REQ-014 SHALL capture req_wen/funct3/addr/wdata on req_valid&req_ready; captured values stay stable until return to IDLE.
REQ-015 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-016 SHALL treat halfword access with addr[0]=1, or word access with addr[1:0]!=0, as misaligned.
REQ-017 SHALL, on an illegal or misaligned request, go IDLE->RESP with resp_err=1 and resp_rdata=0, with no bus request issued.
REQ-018 SHALL, on a legal request, go IDLE->ISSUE; mem_addr={addr[31:2],2'b00}; mem_wen=req_wen.
REQ-019 SHALL drive mem_wmask for stores as follows: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-020 SHALL drive mem_wdata for stores as wdata<<(8*addr[1:0]), and drive mem_wmask=0000 for loads.
REQ-021 SHALL hold mem_req_* stable in ISSUE until mem_req_ready, then go to WAIT on the next cycle.
REQ-022 SHALL, in WAIT on mem_rsp_valid, go to RESP and register the result: resp_err=mem_rsp_err; loads return (mem_rsp_rdata>>(8*addr[1:0])) sign- or zero-extended from 8/16 bits per funct3; stores return resp_rdata=0.
REQ-023 SHALL hold resp_valid/resp_rdata/resp_err stable until resp_ready, then go RESP->IDLE on the next cycle (no same-cycle re-accept).
REQ-024 SHALL clear the timeout counter on entering ISSUE and increment it each cycle in ISSUE/WAIT; when the counter equals TIMEOUT_CYCLES, it SHALL abort to RESP with resp_err=1 and resp_rdata=0.
REQ-025 SHALL give a response event priority over a timeout reached in the same cycle.
REQ-026 SHALL, with zero-wait bus (mem_req_ready and mem_rsp_valid asserted on first opportunity), assert resp_valid 3 cycles after the accept edge.
REQ-027 SHALL ignore mem_rsp_valid outside WAIT; a late beat after a timeout is dropped.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, timeout counter=0, req_ready=1, and drive every other output to 0.
REQ-029 SHALL, on reset mid-access, abandon the access: mem_req_valid drops asynchronously and no response is produced after reset release.

Structure
REQ-030 SHALL take funct3 codes, FSM state encodings and the TIMEOUT width from a shared definitions header (lsu_defs) used by the control/decode logic.
REQ-031 SHALL place byte-lane shift, write-mask generation and load extension in one combinational sub-module, lsu_align; lsu_ctrl holds the FSM, capture registers and counter.

Verification
REQ-032 SHALL cover: LW addr 0x80000004, zero-wait bus, rsp 0xDEADBEEF -> resp_valid at accept+3, rdata 0xDEADBEEF, err 0.
REQ-033 SHALL cover: LB addr 0x80000003, rsp 0x80FF0000 -> rdata 0xFFFFFF80; LBU with same stimulus -> 0x00000080.
REQ-034 SHALL cover: SH addr 0x80000002, wdata 0x1234ABCD -> mem_addr 0x80000000, mem_wmask 1100, mem_wdata 0xABCD0000, resp_rdata 0.
REQ-035 SHALL cover: LW addr 0x80000002 -> resp_valid at accept+1 with err=1, mem_req_valid never asserted.
REQ-036 SHALL cover: TIMEOUT_CYCLES=8 with mem_req_ready tied 0 -> resp_err=1 after 8 cycles in ISSUE; subsequent request served normally.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles -> resp_* stable and req_ready=0 throughout; rst_n pulsed during WAIT -> IDLE with no resp_valid.

Source files
------------

// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// timeout counter width and the request legality check.
package lsu_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_W = 16;

    // True when the request must be answered with an error and never reach the bus.
    function automatic logic req_bad(input logic wen, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic mis;
        if (wen) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        end
        mis = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return !legal || mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store data shift, write-mask generation and
// load data extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_defs::*;
(
    input  logic        wen_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] load_data_o
);

    logic [4:0]  shamt;
    logic [31:0] lane;

    assign shamt = {offset_i, 3'b000};

    always_comb begin
        mem_wdata_o = wdata_i << shamt;
        mem_wmask_o = 4'b0000;
        if (wen_i) begin
            case (funct3_i[1:0])
                2'b00:   mem_wmask_o = 4'b0001 << offset_i;
                2'b01:   mem_wmask_o = 4'b0011 << offset_i;
                default: mem_wmask_o = 4'b1111;
            endcase
        end

        lane = rsp_rdata_i >> shamt;
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data_o = {24'h000000, lane[7:0]};
            F3_HU:   load_data_o = {16'h0000, lane[15:0]};
            default: load_data_o = lane;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time from the execute
// stage, issues it on the bus, and returns the aligned result or an error.
module lsu_ctrl
    import lsu_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and its payload is held until then.

    localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    lsu_state_e           state_q, state_d;
    logic                 wen_q;
    logic [2:0]           f3_q;
    logic [31:0]          addr_q, wdata_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 capture;
    logic                 timeout_hit;
    logic [31:0]          load_data;

    lsu_align u_align (
        .wen_i       (wen_q),
        .funct3_i    (f3_q),
        .offset_i    (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rsp_rdata_i (mem_rsp_rdata),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (mem_wmask),
        .load_data_o (load_data)
    );

    assign cnt_inc     = cnt_q + TIMEOUT_W'(1);
    assign timeout_hit = (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (req_bad(req_wen, req_funct3, req_addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // A response landing on the timeout cycle still wins.
                if (mem_rsp_valid) begin
                    state_d = ST_RESP;
                    err_d   = mem_rsp_err;
                    rdata_d = wen_q ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                wen_q   <= req_wen;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_rsp_ready = (state_q == ST_WAIT);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_wen       = wen_q;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: randomized accesses against a byte-level memory model,
// a bus responder with selectable stall behaviour and a response scoreboard.
module tb_lsu_ctrl;

    localparam int BM_RAND      = 0;
    localparam int BM_ZERO      = 1;
    localparam int BM_STALL_REQ = 2;
    localparam int BM_STALL_RSP = 3;
    localparam int BM_NO_RSP    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    int          bus_mode = BM_RAND;
    int          rr_hold_cfg = 0;
    logic        bus_busy = 1'b0;
    int          bus_accepts = 0;

    logic [40:0] exp_q[$];      // {latency (0 = unchecked), err, rdata}
    logic [68:0] bus_exp_q[$];  // {wen, word addr, wmask, wdata}
    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] bus_mem[logic [29:0]];

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word(a);
    endfunction

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        if (bus_mem.exists(a[31:2])) return bus_mem[a[31:2]];
        return init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a[31:2]] = d;
        bus_mem[a[31:2]] = d;
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int mode, input int hold);
        int          nb, off, lat, guard;
        logic        legal, mis, region, e;
        logic [31:0] w, v;
        logic [3:0]  mask;
        bus_mode    = mode;
        rr_hold_cfg = hold;
        @(negedge clk);
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_accept", {31'h0, req_ready}, 32'h1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        accept_cyc = cyc + 1;

        off    = int'(addr[1:0]);
        nb     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal  = wen ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis    = (off % nb) != 0;
        region = (addr[31:28] == 4'hF);
        v = 32'h0;
        e = 1'b0;
        lat = 0;
        if (!legal || mis) begin
            e = 1'b1;
            lat = 1;
        end else begin
            if (mode == BM_STALL_REQ || mode == BM_STALL_RSP) begin
                e = 1'b1;
                lat = 9;
            end else begin
                e = region;
                lat = (mode == BM_ZERO) ? 3 : 0;
            end
            if (mode != BM_STALL_REQ) begin
                mask = 4'b0000;
                if (wen) for (int i = 0; i < nb; i++) mask[off + i] = 1'b1;
                bus_exp_q.push_back({wen, addr[31:2], 2'b00, mask, wdata << (8 * off)});
                if (wen && !region) begin
                    w = ref_read(addr);
                    for (int i = 0; i < nb; i++) w[8 * (off + i) +: 8] = wdata[8 * i +: 8];
                    ref_mem[addr[31:2]] = w;
                end
            end
            if (!wen && (mode == BM_RAND || mode == BM_ZERO || mode == BM_NO_RSP)) begin
                w = ref_read(addr);
                for (int i = 0; i < nb; i++) v[8 * i +: 8] = w[8 * (off + i) +: 8];
                if (!f3[2] && nb < 4 && v[8 * nb - 1])
                    for (int i = nb; i < 4; i++) v[8 * i +: 8] = 8'hFF;
            end
        end
        exp_q.push_back({8'(lat), e, v});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus_busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", {31'h0, (g < 200)}, 32'h1);
        if (g >= 200) begin
            exp_q.delete();
            bus_exp_q.delete();
        end
    endtask

    task automatic reset_mid(input int mode);
        int g, acc0;
        acc0 = bus_accepts;
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, mode, 0);
        if (mode == BM_NO_RSP) begin
            g = 0;
            while (bus_accepts == acc0 && g < 20) begin
                @(negedge clk);
                g++;
            end
            check("bus_accept_before_reset", {31'h0, (bus_accepts != acc0)}, 32'h1);
            @(negedge clk);
            check("mem_rsp_ready_in_wait", {31'h0, mem_rsp_ready}, 32'h1);
        end else begin
            repeat (3) @(negedge clk);
            check("mem_req_valid_in_issue", {31'h0, mem_req_valid}, 32'h1);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mid_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_mid_mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h0);
        check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_mode = BM_RAND;
        repeat (12) @(negedge clk);
        check("no_resp_after_reset", {31'h0, resp_valid}, 32'h0);
        wait_idle();
    endtask

    // ---------------- bus responder ----------------
    initial begin : responder
        int          d;
        logic [68:0] be;
        logic [31:0] w;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid && bus_mode != BM_STALL_REQ) begin
                if (bus_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no bus request", mem_addr);
                end else begin
                    bus_busy = 1'b1;
                    d = (bus_mode == BM_RAND) ? $urandom_range(0, 2) : 0;
                    repeat (d) @(negedge clk);
                    be = bus_exp_q.pop_front();
                    check("mem_req_valid_held", {31'h0, mem_req_valid}, 32'h1);
                    check("mem_addr", mem_addr, be[67:36]);
                    check("mem_wen", {31'h0, mem_wen}, {31'h0, be[68]});
                    check("mem_wmask", {28'h0, mem_wmask}, {28'h0, be[35:32]});
                    if (be[68]) check("mem_wdata", mem_wdata, be[31:0]);
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    bus_accepts++;
                    if (mem_wen && mem_addr[31:28] != 4'hF) begin
                        w = bus_read(mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (mem_wmask[i]) w[8 * i +: 8] = mem_wdata[8 * i +: 8];
                        bus_mem[mem_addr[31:2]] = w;
                    end
                    if (bus_mode == BM_STALL_RSP) begin
                        repeat (10) @(negedge clk);
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = 32'hBAD0_BAD0;
                        mem_rsp_err   = 1'b0;
                        @(negedge clk);
                        mem_rsp_valid = 1'b0;
                    end else if (bus_mode != BM_NO_RSP) begin
                        d = (bus_mode == BM_RAND) ? $urandom_range(0, 2) : 0;
                        repeat (d) @(negedge clk);
                        check("mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h1);
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = bus_read(be[67:36]);
                        mem_rsp_err   = (be[67:64] == 4'hF);
                        @(negedge clk);
                        mem_rsp_valid = 1'b0;
                    end
                    bus_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    initial begin : monitor
        logic        in_resp;
        int          hold;
        int unsigned first_cyc;
        logic [31:0] h_rdata;
        logic        h_err;
        logic [40:0] e;
        resp_ready = 1'b0;
        in_resp = 1'b0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp = 1'b0;
                resp_ready = 1'b0;
            end else if (resp_valid) begin
                if (!in_resp) begin
                    in_resp   = 1'b1;
                    first_cyc = cyc;
                    h_rdata   = resp_rdata;
                    h_err     = resp_err;
                    hold      = (rr_hold_cfg != 0) ? rr_hold_cfg : $urandom_range(0, 2);
                    rr_hold_cfg = 0;
                end else begin
                    check("resp_rdata_stable", resp_rdata, h_rdata);
                    check("resp_err_stable", {31'h0, resp_err}, {31'h0, h_err});
                end
                check("req_ready_during_resp", {31'h0, req_ready}, 32'h0);
                if (hold == 0) begin
                    resp_ready = 1'b1;
                    in_resp = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got rdata 0x%08h err %0d, expected no response", resp_rdata, resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, e[31:0]);
                        check("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                        if (e[40:33] != 8'd0)
                            check("resp_latency", first_cyc + 1 - accept_cyc, {24'h0, e[40:33]});
                    end
                end else begin
                    resp_ready = 1'b0;
                    hold--;
                end
            end else begin
                resp_ready = 1'b0;
                if (in_resp) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL resp_valid_dropped: got 0, expected resp_valid held until resp_ready");
                    in_resp = 1'b0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r, mode;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        preload(32'h8000_0004, 32'hDEAD_BEEF);
        preload(32'h8000_0000, 32'h80FF_0000);
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b000, 32'h8000_0003, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b100, 32'h8000_0003, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, BM_ZERO, 0);  wait_idle();
        issue(1'b0, 3'b010, 32'h8000_0000, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b010, 32'h8000_0002, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b001, 32'h8000_0001, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b011, 32'h8000_0000, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b1, 3'b100, 32'h8000_0000, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b010, 32'h8000_0008, 32'h0, BM_STALL_REQ, 0);     wait_idle();
        issue(1'b0, 3'b101, 32'h8000_0002, 32'h0, BM_ZERO, 0);          wait_idle();
        issue(1'b0, 3'b010, 32'h8000_000C, 32'h0, BM_STALL_RSP, 0);     wait_idle();
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0, BM_ZERO, 5);          wait_idle();
        issue(1'b1, 3'b000, 32'hF000_0001, 32'h0000_00AA, BM_ZERO, 0);  wait_idle();

        for (int n = 0; n < 150; n++) begin
            wen  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? 32'hF000_0000 + $urandom_range(0, 15)
                                               : 32'h8000_0000 + $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else begin
                r  = wen ? $urandom_range(0, 2) : $urandom_range(0, 4);
                f3 = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
            end
            r = $urandom_range(0, 19);
            mode = (r == 0) ? BM_STALL_REQ : (r == 1) ? BM_STALL_RSP : (r < 7) ? BM_ZERO : BM_RAND;
            issue(wen, f3, addr, $urandom, mode, 0);
            wait_idle();
        end

        reset_mid(BM_NO_RSP);
        reset_mid(BM_STALL_REQ);
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0, BM_ZERO, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got no completion, expected run to finish within 1ms");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
